// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: buffers N A-columns / B-rows,
// then streams them with a one-cycle-per-lane skew, followed by a drain interval.
module systolic_feeder #(
    parameter int data_size = 8,
    parameter int N         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*data_size-1:0] in_a_vec,
    input  logic [N*data_size-1:0] in_b_vec,
    output logic [N*data_size-1:0] out_a,
    output logic [N*data_size-1:0] out_b,
    output logic                   out_clear,
    output logic                   out_busy,
    output logic                   out_done
);

    localparam int KW = $clog2(N);
    localparam int SW = $clog2(3*N-2);

    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [KW-1:0] LAST_BEAT = KW'(N-1);
    localparam logic [SW-1:0] LAST_STEP = SW'(3*N-3);

    typedef logic [N-1:0][data_size-1:0] vec_t;

    vec_t          a_buf [N];
    vec_t          b_buf [N];
    vec_t          in_a, in_b;
    vec_t          a_nxt, b_nxt;
    vec_t          a_q, b_q;
    logic [1:0]    state;
    logic [KW-1:0] beat;
    logic [SW-1:0] step;
    logic [SW-1:0] nxt_step;
    logic          accept;

    assign in_a   = in_a_vec;
    assign in_b   = in_b_vec;
    assign out_a  = a_q;
    assign out_b  = b_q;
    assign accept = in_ready && in_valid;

    // Step the registers will present next: step 0 leaves CLEAR, then s+1.
    assign nxt_step = (state == CLEAR) ? '0 : step + SW'(1);

    // Lane i shows slot (s-i); steps outside every lane's window fall to zero,
    // which also covers the drain interval.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (nxt_step == SW'(i + k)) begin
                    a_nxt[i] = a_buf[k][i];
                    b_nxt[i] = b_buf[k][i];
                end
            end
        end
    end

    // Operand storage carries no reset; the beat counter alone defines validity.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            a_buf[beat] <= in_a;
            b_buf[beat] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LOAD;
            beat      <= '0;
            step      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_clear <= 1'b0;
            out_busy  <= 1'b0;
            out_done  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_clear <= 1'b0;
            out_done  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (beat == LAST_BEAT) begin
                            beat      <= '0;
                            state     <= CLEAR;
                            out_clear <= 1'b1;
                            out_busy  <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            beat <= beat + KW'(1);
                        end
                    end
                end
                CLEAR: begin
                    state <= STREAM;
                    step  <= nxt_step;
                    a_q   <= a_nxt;
                    b_q   <= b_nxt;
                end
                STREAM: begin
                    if (step == LAST_STEP) begin
                        state    <= DONE;
                        step     <= '0;
                        out_done <= 1'b1;
                    end else begin
                        step <= nxt_step;
                        a_q  <= a_nxt;
                        b_q  <= b_nxt;
                    end
                end
                default: begin
                    state    <= LOAD;
                    out_busy <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (N=4, data_size=8): stimulus pushes
// expected busy-cycle frames, a negedge monitor pops and compares them.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DS = 8;
    localparam int NS = 3*N-2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [N*DS-1:0] in_a_vec, in_b_vec;
    logic [N*DS-1:0] out_a, out_b;
    logic            out_clear, out_busy, out_done;

    systolic_feeder #(.data_size(DS), .N(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_vec(in_a_vec), .in_b_vec(in_b_vec), .out_a(out_a), .out_b(out_b),
        .out_clear(out_clear), .out_busy(out_busy), .out_done(out_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            clr;
        logic            done;
        logic [N*DS-1:0] a;
        logic [N*DS-1:0] b;
    } frame_t;

    frame_t      exp_q [$];
    logic [7:0]  tb_a [N][N];
    logic [7:0]  tb_b [N][N];
    logic [31:0] cap_a [NS];
    logic [31:0] cap_b [NS];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          sidx = 0;
    int          c0 = 0;
    int          dc0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every busy cycle is one frame the DUT presents.
    always @(negedge clk) begin
        frame_t f;
        if (reset === 1'b1 && out_busy === 1'b1) begin
            if (out_clear === 1'b1) sidx = 0;
            else if (out_done !== 1'b1 && sidx < NS) begin
                cap_a[sidx] = out_a;
                cap_b[sidx] = out_b;
                sidx++;
            end
            if (out_done === 1'b1) done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame clr=%b done=%b a=%h b=%h", out_clear, out_done, out_a, out_b);
            end else begin
                f = exp_q.pop_front();
                chk("frame", {in_ready, out_clear, out_done, out_a, out_b},
                    {1'b0, f.clr, f.done, f.a, f.b});
            end
        end
    end

    task automatic push_frames();
        frame_t f;
        f.clr = 1'b1; f.done = 1'b0; f.a = '0; f.b = '0;
        exp_q.push_back(f);
        for (int s = 0; s < NS; s++) begin
            f.clr = 1'b0; f.a = '0; f.b = '0;
            for (int i = 0; i < N; i++) begin
                if (s - i >= 0 && s - i < N) begin
                    f.a[i*DS +: DS] = tb_a[s-i][i];
                    f.b[i*DS +: DS] = tb_b[s-i][i];
                end
            end
            exp_q.push_back(f);
        end
        f.clr = 1'b0; f.done = 1'b1; f.a = '0; f.b = '0;
        exp_q.push_back(f);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        chk("rst_outs", {out_a, out_b, out_clear, out_busy, out_done}, '0);
        exp_q.delete();
        reset = 1'b1;
        tick();
        chk("rst_ready", in_ready, 1'b1);
    endtask

    // Beat k lane i: A = ba+16k+i, B = bb+16k+i. With gaps, an idle
    // junk-data cycle precedes every beat.
    task automatic load(input logic [7:0] ba, input logic [7:0] bb, input bit gaps);
        dc0 = done_cnt;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_a_vec = $urandom;
                in_b_vec = $urandom;
                tick();
                chk("ready_gap", in_ready, 1'b1);
            end
            for (int i = 0; i < N; i++) begin
                tb_a[k][i] = ba + 8'(16*k + i);
                tb_b[k][i] = bb + 8'(16*k + i);
                in_a_vec[i*DS +: DS] = tb_a[k][i];
                in_b_vec[i*DS +: DS] = tb_b[k][i];
            end
            in_valid = 1'b1;
            tick();
            if (k < N-1) chk("ready_load", in_ready, 1'b1);
        end
        c0 = cyc;
        push_frames();
        chk("ready_drop", in_ready, 1'b0);
    endtask

    task automatic finish_pass(input bit hold);
        bit seen = 1'b0;
        if (!hold) in_valid = 1'b0;
        for (int t = 0; t < 3*N+8; t++) begin
            tick();
            if (hold) begin
                in_a_vec = $urandom;
                in_b_vec = $urandom;
            end
            if (out_done === 1'b1) begin
                seen = 1'b1;
                chk("done_lat", 80'(cyc - c0), 80'(3*N-1));
                break;
            end
        end
        in_valid = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout act=none exp=out_done");
        end
        tick();
        chk("ready_back", {in_ready, out_busy}, 2'b10);
        chk("q_drained", 80'(exp_q.size()), 80'(0));
        chk("done_once", 80'(done_cnt), 80'(dc0 + 1));
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_a_vec = '0;
        in_b_vec = '0;
        do_reset();

        // Back-to-back beats
        load(8'h00, 8'h80, 1'b0);
        finish_pass(1'b0);
        chk("s0_a", cap_a[0], 32'h00000000);
        chk("s0_b", cap_b[0], 32'h00000080);
        chk("s3_a", cap_a[3], 32'h03122130);
        chk("s3_b", cap_b[3], 32'h8392A1B0);
        for (int s = 7; s <= 9; s++)
            chk("drain_zero", {cap_a[s], cap_b[s]}, 64'h0);

        // Toggling in_valid during LOAD
        load(8'h00, 8'h80, 1'b1);
        finish_pass(1'b0);
        chk("gap_s3_a", cap_a[3], 32'h03122130);
        chk("gap_s3_b", cap_b[3], 32'h8392A1B0);

        // in_valid held high with changing data through the pass
        load(8'h40, 8'hC0, 1'b0);
        finish_pass(1'b1);
        chk("hold_s3_a", cap_a[3], 32'h43526170);
        chk("hold_s3_b", cap_b[3], 32'hC3D2E1F0);

        // Reset during STREAM step 4
        load(8'h20, 8'hA0, 1'b0);
        in_valid = 1'b0;
        repeat (5) tick();
        chk("abort_s4_a", out_a, 32'h33425100);
        reset = 1'b0;
        tick();
        chk("abort_outs", {out_a, out_b, out_clear, out_busy, out_done}, '0);
        chk("abort_ready", in_ready, 1'b1);
        exp_q.delete();
        reset = 1'b1;
        dc0 = done_cnt;
        repeat (3*N+4) tick();
        chk("abort_no_done", 80'(done_cnt), 80'(dc0));
        chk("abort_idle", {in_ready, out_busy}, 2'b10);

        // Fresh load after abort
        load(8'h10, 8'h90, 1'b0);
        finish_pass(1'b0);
        chk("fresh_s3_a", cap_a[3], 32'h13223140);
        chk("fresh_s3_b", cap_b[3], 32'h93A2B1C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
